// File: rtl/game_regs_pkg.sv
// Shared definitions for the game status register block: default timing
// parameters, fruit bit positions, the BCD converter state encoding and the
// shift-add-3 step used by the converter.
package game_pkg;

  localparam int TIME_LIMIT_DEFAULT = 120;
  localparam int FPS_DEFAULT        = 60;

  localparam int FRUIT_APPLE  = 0;
  localparam int FRUIT_PEAS   = 1;
  localparam int FRUIT_GRAPES = 2;
  localparam int FRUIT_DRINK  = 3;

  localparam int LIVES_MAX_LOST = 2;

  // One shift-add-3 iteration per input bit of the 10-bit score.
  localparam int BCD_ITERS = 10;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_DONE  = 2'd2
  } bcd_state_t;

  // One double-dabble step on {digits[15:0], binary[9:0]}: bump every digit
  // that is 5 or more by 3, then shift the whole word left by one.
  function automatic logic [25:0] add3_shift(input logic [25:0] w);
    logic [25:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      if (t[10 + 4*i +: 4] >= 4'd5) begin
        t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
      end else begin
        t[10 + 4*i +: 4] = t[10 + 4*i +: 4];
      end
    end
    return {t[24:0], 1'b0};
  endfunction

endpackage

// File: rtl/game_regs_if.sv
// Bundle of the write strobes/data from the game-logic FSM and the values the
// register block drives back to it and to the HUD.
interface game_regs_if;

  logic        Load_S;
  logic        Load_F;
  logic        Load_L;
  logic [9:0]  score_to_reg;
  logic [3:0]  fruits_to_reg;
  logic [7:0]  lives_to_reg;

  logic [9:0]  score_from_reg;
  logic [3:0]  fruits_from_reg;
  logic [7:0]  lives_from_reg;
  logic [31:0] counter;
  logic [15:0] score_bcd;
  logic        bcd_busy;

  modport master (
    output Load_S, Load_F, Load_L, score_to_reg, fruits_to_reg, lives_to_reg,
    input  score_from_reg, fruits_from_reg, lives_from_reg, counter,
           score_bcd, bcd_busy
  );

  modport slave (
    input  Load_S, Load_F, Load_L, score_to_reg, fruits_to_reg, lives_to_reg,
    output score_from_reg, fruits_from_reg, lives_from_reg, counter,
           score_bcd, bcd_busy
  );

endinterface

// File: rtl/game_regs_bin2bcd_seq.sv
// Sequential 10-bit binary to 4-digit BCD converter. A start pulse in IDLE
// latches the input; ten SHIFT cycles run the shift-add-3 steps; the DONE
// cycle publishes the finished digits so the output never shows a partial
// result. busy flags the SHIFT phase, done flags the DONE cycle.
module bin2bcd_seq
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done
);

  bcd_state_t  state;
  bcd_state_t  state_next;
  logic [3:0]  iter;
  logic [25:0] work;
  logic [15:0] bcd_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BCD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: leave SHIFT on the tenth iteration.
  always_comb begin
    state_next = state;
    case (state)
      BCD_IDLE: begin
        if (start) begin
          state_next = BCD_SHIFT;
        end else begin
          state_next = BCD_IDLE;
        end
      end
      BCD_SHIFT: begin
        if (iter == 4'(BCD_ITERS - 1)) begin
          state_next = BCD_DONE;
        end else begin
          state_next = BCD_SHIFT;
        end
      end
      BCD_DONE: state_next = BCD_IDLE;
      default:  state_next = BCD_IDLE;
    endcase
  end

  // Datapath: latch on start, iterate in SHIFT, publish digits in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter  <= 4'd0;
      work  <= 26'd0;
      bcd_q <= 16'h0000;
    end else begin
      case (state)
        BCD_IDLE: begin
          if (start) begin
            work <= {16'h0000, bin};
            iter <= 4'd0;
          end else begin
            work <= work;
          end
        end
        BCD_SHIFT: begin
          work <= add3_shift(work);
          iter <= iter + 4'd1;
        end
        BCD_DONE: bcd_q <= work[25:10];
        default:  bcd_q <= bcd_q;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state == BCD_SHIFT);
  assign done = (state == BCD_DONE);

endmodule

// File: rtl/game_regs.sv
// Game status registers (score, fruit mask, lives lost), the seconds
// countdown driven by frame ticks, and the score-to-BCD conversion with a
// pending flag so a score written mid-conversion is always converted too.
module game_regs
  import game_pkg::*;
#(
  parameter int TIME_LIMIT     = TIME_LIMIT_DEFAULT,
  parameter int FRAMES_PER_SEC = FPS_DEFAULT
)
(
  input logic        Clk,
  input logic        Reset,
  input logic        frame_tick,
  input logic        pause,
  game_regs_if.slave bus
);

  localparam int CNT_W = $clog2(TIME_LIMIT + 1);
  localparam int PRE_W = $clog2(FRAMES_PER_SEC + 1);

  logic [9:0]       score;
  logic [3:0]       fruits;
  logic [7:0]       lives;
  logic [CNT_W-1:0] seconds;
  logic [PRE_W-1:0] prescale;
  logic             load_s_q;
  logic             pending;
  logic             conv_start;
  logic             conv_shift;
  logic             conv_done;
  logic [15:0]      bcd_val;

  // Status registers: each loads on its own strobe, independently of the others.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      score    <= 10'd0;
      fruits   <= 4'd0;
      lives    <= 8'd0;
      load_s_q <= 1'b0;
    end else begin
      if (bus.Load_S) score  <= bus.score_to_reg;
      if (bus.Load_F) fruits <= bus.fruits_to_reg;
      if (bus.Load_L) lives  <= bus.lives_to_reg;
      load_s_q <= bus.Load_S;
    end
  end

  // Countdown: prescale frame ticks to seconds; frozen by pause, stops at zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prescale <= {PRE_W{1'b0}};
      seconds  <= CNT_W'(TIME_LIMIT);
    end else if (frame_tick && !pause && (seconds != {CNT_W{1'b0}})) begin
      if (prescale == PRE_W'(FRAMES_PER_SEC - 1)) begin
        prescale <= {PRE_W{1'b0}};
        seconds  <= seconds - CNT_W'(1);
      end else begin
        prescale <= prescale + PRE_W'(1);
      end
    end
  end

  // Start a conversion from idle after a score write or a deferred request.
  always_comb begin
    conv_start = (load_s_q | pending) & ~(conv_shift | conv_done);
  end

  // Pending flag: a score write that cannot start its own conversion now
  // (engine busy, or the engine is latching the previous value this cycle).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending <= 1'b0;
    end else if (bus.Load_S && (conv_shift || conv_done || conv_start)) begin
      pending <= 1'b1;
    end else if (conv_start) begin
      pending <= 1'b0;
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (Clk),
    .rst   (Reset),
    .start (conv_start),
    .bin   (score),
    .bcd   (bcd_val),
    .busy  (conv_shift),
    .done  (conv_done)
  );

  assign bus.score_from_reg  = score;
  assign bus.fruits_from_reg = fruits;
  assign bus.lives_from_reg  = lives;
  assign bus.counter         = {{(32 - CNT_W){1'b0}}, seconds};
  assign bus.score_bcd       = bcd_val;
  assign bus.bcd_busy        = conv_shift | conv_done;

endmodule

// File: tb/tb_game_regs.sv
// Self-checking bench for game_regs: a vector table for the register strobes,
// then hand-written sequences for BCD latency, load-during-conversion,
// timer/pause behaviour and reset in the middle of a conversion.
module tb_game_regs;
  import game_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  logic frame_tick;
  logic pause;

  game_regs_if bus ();

  game_regs #(.TIME_LIMIT(120), .FRAMES_PER_SEC(60)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .pause      (pause),
    .bus        (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       ld_s;
    logic       ld_f;
    logic       ld_l;
    logic [9:0] s;
    logic [3:0] f;
    logic [7:0] l;
    logic [9:0] es;
    logic [3:0] ef;
    logic [7:0] el;
  } vec_t;

  vec_t vecs [8];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    bus.Load_S        = 1'b0;
    bus.Load_F        = 1'b0;
    bus.Load_L        = 1'b0;
    bus.score_to_reg  = 10'd0;
    bus.fruits_to_reg = 4'd0;
    bus.lives_to_reg  = 8'd0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    int         busy_cnt;
    int         rises;
    int         nchg;
    logic       prev_busy;
    logic [15:0] last_bcd;
    logic [15:0] chg [4];

    vecs[0] = '{1'b0, 1'b1, 1'b1, 10'd0,    4'b0101, 8'd1,   10'd0,    4'b0101, 8'd1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 10'd300,  4'b1111, 8'd9,   10'd300,  4'b0101, 8'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 10'd12,   4'b1010, 8'd2,   10'd12,   4'b1010, 8'd2};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 10'd999,  4'b1111, 8'd255, 10'd12,   4'b1010, 8'd2};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 10'd999,  4'b1111, 8'd7,   10'd12,   4'b1111, 8'd2};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 10'd5,    4'b0001, 8'd255, 10'd12,   4'b1111, 8'd255};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 10'd1023, 4'b0000, 8'd0,   10'd1023, 4'b0000, 8'd0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 10'd0,    4'b0001, 8'd3,   10'd1023, 4'b0000, 8'd0};

    // Reset values
    Reset = 1'b1; frame_tick = 1'b0; pause = 1'b0;
    idle_inputs();
    step(); step();
    check("rst_score",   32'(bus.score_from_reg),  32'd0);
    check("rst_fruits",  32'(bus.fruits_from_reg), 32'd0);
    check("rst_lives",   32'(bus.lives_from_reg),  32'd0);
    check("rst_counter", bus.counter,              32'd120);
    check("rst_bcd",     32'(bus.score_bcd),       32'h0000);
    check("rst_busy",    32'(bus.bcd_busy),        32'd0);
    Reset = 1'b0;

    // Register strobe table
    for (int i = 0; i < 8; i++) begin
      bus.Load_S = vecs[i].ld_s; bus.Load_F = vecs[i].ld_f; bus.Load_L = vecs[i].ld_l;
      bus.score_to_reg = vecs[i].s; bus.fruits_to_reg = vecs[i].f; bus.lives_to_reg = vecs[i].l;
      step();
      check($sformatf("vec%0d_score", i),  32'(bus.score_from_reg),  32'(vecs[i].es));
      check($sformatf("vec%0d_fruits", i), 32'(bus.fruits_from_reg), 32'(vecs[i].ef));
      check($sformatf("vec%0d_lives", i),  32'(bus.lives_from_reg),  32'(vecs[i].el));
    end
    idle_inputs();
    repeat (40) step();
    check("table_final_bcd",  32'(bus.score_bcd), 32'h1023);
    check("table_final_busy", 32'(bus.bcd_busy),  32'd0);

    // Score 987: latency and busy window
    bus.score_to_reg = 10'd987; bus.Load_S = 1'b1;
    step();
    idle_inputs();
    check("s987_score", 32'(bus.score_from_reg), 32'd987);
    check("s987_busy0", 32'(bus.bcd_busy),       32'd0);
    busy_cnt = 0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (bus.bcd_busy) busy_cnt++;
      if (k == 11) check("s987_bcd_c11", 32'(bus.score_bcd), 32'h1023);
    end
    step();
    check("s987_busy_cycles", 32'(busy_cnt),      32'd11);
    check("s987_busy_c12",    32'(bus.bcd_busy),  32'd0);
    check("s987_bcd_c12",     32'(bus.score_bcd), 32'h0987);

    // Load during conversion: 50 then 1023 three cycles later
    rises = 0; nchg = 0; prev_busy = bus.bcd_busy; last_bcd = bus.score_bcd;
    for (int k = 0; k < 60; k++) begin
      bus.Load_S = (k == 0 || k == 3);
      bus.score_to_reg = (k == 0) ? 10'd50 : 10'd1023;
      step();
      if (bus.bcd_busy && !prev_busy) rises++;
      prev_busy = bus.bcd_busy;
      if (bus.score_bcd !== last_bcd) begin
        if (nchg < 4) chg[nchg] = bus.score_bcd;
        nchg++;
        last_bcd = bus.score_bcd;
      end
    end
    idle_inputs();
    check("pend_conversions", 32'(rises), 32'd2);
    check("pend_changes",     32'(nchg),  32'd2);
    if (nchg >= 2) begin
      check("pend_first",  32'(chg[0]), 32'h0050);
      check("pend_second", 32'(chg[1]), 32'h1023);
    end

    // Timer and pause
    ticks(59);  check("tmr_59",  bus.counter, 32'd120);
    ticks(1);   check("tmr_60",  bus.counter, 32'd119);
    ticks(60);  check("tmr_120", bus.counter, 32'd118);
    ticks(30);  check("tmr_150", bus.counter, 32'd118);
    pause = 1'b1;
    ticks(90);  check("tmr_paused", bus.counter, 32'd118);
    pause = 1'b0;
    ticks(29);  check("tmr_resume_29", bus.counter, 32'd118);
    ticks(1);   check("tmr_resume_30", bus.counter, 32'd117);
    ticks(117 * 60 - 1); check("tmr_one", bus.counter, 32'd1);
    ticks(1);   check("tmr_zero", bus.counter, 32'd0);
    ticks(200); check("tmr_hold_zero", bus.counter, 32'd0);

    // Reset mid-conversion with a pending request and strobes held
    for (int k = 0; k < 6; k++) begin
      bus.Load_S = (k == 0 || k == 3);
      bus.score_to_reg = (k == 0) ? 10'd500 : 10'd600;
      step();
    end
    check("rmc_busy_before", 32'(bus.bcd_busy), 32'd1);
    Reset = 1'b1;
    bus.Load_S = 1'b1; bus.score_to_reg = 10'd777;
    bus.Load_F = 1'b1; bus.fruits_to_reg = 4'd3;
    bus.Load_L = 1'b1; bus.lives_to_reg = 8'd9;
    step();
    Reset = 1'b0;
    idle_inputs();
    check("rmc_busy",    32'(bus.bcd_busy),        32'd0);
    check("rmc_bcd",     32'(bus.score_bcd),       32'h0000);
    check("rmc_score",   32'(bus.score_from_reg),  32'd0);
    check("rmc_fruits",  32'(bus.fruits_from_reg), 32'd0);
    check("rmc_lives",   32'(bus.lives_from_reg),  32'd0);
    check("rmc_counter", bus.counter,              32'd120);
    busy_cnt = 0;
    repeat (20) begin
      step();
      if (bus.bcd_busy) busy_cnt++;
    end
    check("rmc_pending_lost", 32'(busy_cnt), 32'd0);
    bus.score_to_reg = 10'd7; bus.Load_S = 1'b1;
    step();
    idle_inputs();
    repeat (12) step();
    check("rmc_bcd_7", 32'(bus.score_bcd), 32'h0007);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
